// File: rtl/iso14443a_miller_tx_pkg.sv
// ISO14443-A reader transmit: shared types and defaults.
// Used by both the Miller encoder and the receive path.
package iso14443a_pkg;

  localparam int BIT_LEN_DEF   = 128;
  localparam int PAUSE_LEN_DEF = 32;

  typedef enum logic [1:0] {
    SEQ_X,
    SEQ_Y,
    SEQ_Z
  } seq_t;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    DATA,
    PARITY,
    EOF0,
    EOFY
  } state_t;

endpackage

// File: rtl/iso14443a_miller_tx_if.sv
// Byte handshake between the ARM-facing logic and the
// Miller transmit encoder.
interface iso14443a_miller_tx_if;

  logic [7:0] tx_data;
  logic [2:0] tx_bits;
  logic       tx_par_en;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_bits,
    output tx_par_en,
    output tx_last,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_bits,
    input  tx_par_en,
    input  tx_last,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/iso14443a_miller_tx_seq_gen.sv
// Modified Miller period timer: phase counter, latched
// sequence and registered pause decode.
module miller_seq_gen
  import iso14443a_pkg::*;
#(
  parameter int BIT_LEN   = BIT_LEN_DEF,
  parameter int PAUSE_LEN = PAUSE_LEN_DEF,
  parameter int X_OFFSET  = BIT_LEN / 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic stop_i,
  input  seq_t seq_i,
  output logic pause_o,
  output logic period_end_o
);

  localparam int PW = $clog2(BIT_LEN);
  localparam logic [PW-1:0] PH_LAST = PW'(BIT_LEN - 1);
  localparam logic [PW-1:0] PL = PW'(PAUSE_LEN);
  localparam logic [PW-1:0] XS = PW'(X_OFFSET);
  localparam logic [PW-1:0] XE = PW'(X_OFFSET + PAUSE_LEN);

  logic          active_q, active_d;
  logic [PW-1:0] phase_q, phase_d;
  seq_t          seq_q, seq_d;
  logic          pause_q, pause_d;

  function automatic logic decode(seq_t s, logic [PW-1:0] ph);
    return ((s == SEQ_Z) && (ph < PL)) ||
           ((s == SEQ_X) && (ph >= XS) && (ph < XE));
  endfunction

  assign period_end_o = active_q && (phase_q == PH_LAST);
  assign pause_o      = pause_q;

  // Pause is decoded for the phase that will be shown next cycle.
  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    seq_d    = seq_q;
    pause_d  = pause_q;
    if (start_i || (period_end_o && !stop_i)) begin
      active_d = 1'b1;
      phase_d  = '0;
      seq_d    = seq_i;
      pause_d  = decode(seq_i, '0);
    end else if (period_end_o) begin
      active_d = 1'b0;
      phase_d  = '0;
      pause_d  = 1'b0;
    end else if (active_q) begin
      phase_d = phase_q + 1'b1;
      pause_d = decode(seq_q, phase_d);
    end
  end

  // Period state registers; reset drops the pause at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      phase_q  <= '0;
      seq_q    <= SEQ_Y;
      pause_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      seq_q    <= seq_d;
      pause_q  <= pause_d;
    end
  end

endmodule

// File: rtl/iso14443a_miller_tx.sv
// ISO14443-A 106 kbps reader transmit encoder: holding
// buffer, shift register, parity and frame FSM.
module iso14443a_miller_tx
  import iso14443a_pkg::*;
#(
  parameter int BIT_LEN   = BIT_LEN_DEF,
  parameter int PAUSE_LEN = PAUSE_LEN_DEF,
  parameter int X_OFFSET  = BIT_LEN / 2
) (
  input  logic                  osc_clk,
  input  logic                  nrst,
  iso14443a_miller_tx_if.slave  tx,
  output logic                  mod_pause,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  state_t     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [3:0] cnt_q, cnt_d;
  logic       par_q, par_d;
  logic       pen_q, pen_d;
  logic       last_q, last_d;
  logic       cur_q, cur_d;
  logic       bfull_q, bfull_d;
  logic [7:0] bdata_q, bdata_d;
  logic [2:0] bbits_q, bbits_d;
  logic       bpar_q, bpar_d;
  logic       blast_q, blast_d;
  logic       done_q, done_d;
  logic       und_q, und_d;

  logic load, start, stop, pe;
  logic use_bit, nbit, end_byte;
  seq_t seq_nx;

  assign tx.tx_ready = ~bfull_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign underrun    = und_q;

  miller_seq_gen #(
    .BIT_LEN   (BIT_LEN),
    .PAUSE_LEN (PAUSE_LEN),
    .X_OFFSET  (X_OFFSET)
  ) u_seq (
    .clk          (osc_clk),
    .rst_n        (nrst),
    .start_i      (start),
    .stop_i       (stop),
    .seq_i        (seq_nx),
    .pause_o      (mod_pause),
    .period_end_o (pe)
  );

  // Frame FSM: picks the next period's logic value at period end.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    pen_d    = pen_q;
    last_d   = last_q;
    cur_d    = cur_q;
    load     = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    use_bit  = 1'b0;
    nbit     = 1'b0;
    end_byte = 1'b0;
    seq_nx   = SEQ_Z;
    done_d   = 1'b0;
    und_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bfull_q) begin
          load    = 1'b1;
          start   = 1'b1;
          state_d = SOF;
          cur_d   = 1'b0;
        end
      end
      SOF: begin
        if (pe) begin
          state_d = DATA;
          use_bit = 1'b1;
          nbit    = sh_q[0];
        end
      end
      DATA: begin
        if (pe) begin
          if (cnt_q > 4'd1) begin
            sh_d    = sh_q >> 1;
            cnt_d   = cnt_q - 4'd1;
            use_bit = 1'b1;
            nbit    = sh_q[1];
          end else if (pen_q) begin
            state_d = PARITY;
            use_bit = 1'b1;
            nbit    = par_q;
          end else begin
            end_byte = 1'b1;
          end
        end
      end
      PARITY: begin
        if (pe) end_byte = 1'b1;
      end
      EOF0: begin
        if (pe) begin
          state_d = EOFY;
          seq_nx  = SEQ_Y;
        end
      end
      EOFY: begin
        if (pe) begin
          state_d = IDLE;
          stop    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
    if (end_byte) begin
      use_bit = 1'b1;
      if (last_q) begin
        state_d = EOF0;
      end else if (bfull_q) begin
        load    = 1'b1;
        state_d = DATA;
        nbit    = bdata_q[0];
      end else begin
        und_d   = 1'b1;
        state_d = EOF0;
      end
    end
    if (use_bit) begin
      cur_d  = nbit;
      seq_nx = nbit ? SEQ_X : (cur_q ? SEQ_Y : SEQ_Z);
    end
    if (load) begin
      sh_d   = bdata_q;
      cnt_d  = (bbits_q == 3'd0) ? 4'd8 : {1'b0, bbits_q};
      par_d  = ~^bdata_q;
      pen_d  = bpar_q;
      last_d = blast_q;
    end
  end

  // One-byte holding buffer; loading frees it on the same edge.
  always_comb begin
    bfull_d = bfull_q;
    bdata_d = bdata_q;
    bbits_d = bbits_q;
    bpar_d  = bpar_q;
    blast_d = blast_q;
    if (load) begin
      bfull_d = 1'b0;
    end else if (tx.tx_valid && !bfull_q) begin
      bfull_d = 1'b1;
      bdata_d = tx.tx_data;
      bbits_d = tx.tx_bits;
      bpar_d  = tx.tx_par_en;
      blast_d = tx.tx_last;
    end
  end

  // Frame and buffer state registers.
  always_ff @(posedge osc_clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      last_q  <= 1'b0;
      cur_q   <= 1'b0;
      bfull_q <= 1'b0;
      bdata_q <= '0;
      bbits_q <= '0;
      bpar_q  <= 1'b0;
      blast_q <= 1'b0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      bfull_q <= bfull_d;
      bdata_q <= bdata_d;
      bbits_q <= bbits_d;
      bpar_q  <= bpar_d;
      blast_q <= blast_d;
      done_q  <= done_d;
      und_q   <= und_d;
    end
  end

endmodule

// File: tb/tb_iso14443a_miller_tx.sv
// Bench for iso14443a_miller_tx: PAUSE_LEN 32 and 20 in
// lockstep against a per-cycle waveform scoreboard.
module tb_iso14443a_miller_tx;

  localparam int BL  = 128;
  localparam int XO  = 64;
  localparam int PL1 = 32;
  localparam int PL2 = 20;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic mp1, bz1, dn1, un1;
  logic mp2, bz2, dn2, un2;

  iso14443a_miller_tx_if tif ();
  iso14443a_miller_tx_if tif2 ();

  assign tif2.tx_data   = tif.tx_data;
  assign tif2.tx_bits   = tif.tx_bits;
  assign tif2.tx_par_en = tif.tx_par_en;
  assign tif2.tx_last   = tif.tx_last;
  assign tif2.tx_valid  = tif.tx_valid;

  iso14443a_miller_tx #(.BIT_LEN(BL), .PAUSE_LEN(PL1)) dut (
    .osc_clk   (clk),
    .nrst      (nrst),
    .tx        (tif),
    .mod_pause (mp1),
    .busy      (bz1),
    .done      (dn1),
    .underrun  (un1)
  );

  iso14443a_miller_tx #(.BIT_LEN(BL), .PAUSE_LEN(PL2)) dut20 (
    .osc_clk   (clk),
    .nrst      (nrst),
    .tx        (tif2),
    .mod_pause (mp2),
    .busy      (bz2),
    .done      (dn2),
    .underrun  (un2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic p1;
    logic p2;
    logic dn;
    logic un;
    logic bz;
  } exp_t;

  typedef struct {
    int         nb;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [2:0] b0;
    logic [2:0] b1;
    logic       p0;
    logic       p1;
    logic       lst;
    int         exp_len;
    int         exp_und;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[7];

  int n_chk = 0;
  int n_fail = 0;

  logic go = 1'b0;
  logic run = 1'b0;
  int idx, werr, done_idx, dn_cnt, und_cnt;
  int w2, wmin, wmax;
  logic prv1, prv2;
  int rises[$];
  int exp_r[7] = '{0, 128, 320, 448, 640, 832, 1024};
  int w;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic pz(input int s, input int ph, input int pl);
    return (s == 2 && ph < pl) || (s == 0 && ph >= XO && ph < XO + pl);
  endfunction

  // Spec-level model: bits -> Miller sequences -> per-cycle outputs.
  task automatic push_model(input vec_t v);
    logic bq[$];
    int sq[$];
    logic prv;
    logic [7:0] d;
    int n;
    exp_t x;
    for (int k = 0; k < v.nb; k++) begin
      d = (k == 0) ? v.d0 : v.d1;
      n = (k == 0) ? int'(v.b0) : int'(v.b1);
      if (n == 0) n = 8;
      for (int i = 0; i < n; i++) bq.push_back(d[i]);
      if ((k == 0) ? v.p0 : v.p1) bq.push_back(~^d);
    end
    sq.push_back(2);
    prv = 1'b0;
    foreach (bq[i]) begin
      sq.push_back(bq[i] ? 0 : (prv ? 1 : 2));
      prv = bq[i];
    end
    sq.push_back(prv ? 1 : 2);
    sq.push_back(1);
    foreach (sq[k]) begin
      for (int ph = 0; ph < BL; ph++) begin
        x.p1 = pz(sq[k], ph, PL1);
        x.p2 = pz(sq[k], ph, PL2);
        x.dn = 1'b0;
        x.un = !v.lst && (k == bq.size() + 1) && (ph == 0);
        x.bz = 1'b1;
        sb.push_back(x);
      end
    end
    x = '{p1: 1'b0, p2: 1'b0, dn: 1'b1, un: 1'b0, bz: 1'b0};
    sb.push_back(x);
  endtask

  // Monitor: pop one expected record per cycle once a frame starts.
  always @(negedge clk) begin
    if (go) begin
      go  = 1'b0;
      run = 1'b1;
      idx = 0;
    end else if (run && sb.size() > 0) begin
      e = sb.pop_front();
      if ({mp1, mp2, dn1, un1, bz1} !== {e.p1, e.p2, e.dn, e.un, e.bz})
        werr++;
      if (dn1) begin
        done_idx = idx;
        dn_cnt++;
      end
      if (un1) und_cnt++;
      if (mp1 && !prv1) rises.push_back(idx);
      if (mp2) w2++;
      else if (prv2) begin
        if (w2 < wmin) wmin = w2;
        if (w2 > wmax) wmax = w2;
        w2 = 0;
      end
      prv1 = mp1;
      prv2 = mp2;
      idx++;
      if (sb.size() == 0) run = 1'b0;
    end
  end

  task automatic clear();
    werr = 0; done_idx = -1; dn_cnt = 0; und_cnt = 0;
    w2 = 0; wmin = 1000000; wmax = 0;
    prv1 = 1'b0; prv2 = 1'b0;
    rises.delete();
  endtask

  task automatic offer(input logic [7:0] d, input logic [2:0] b,
                       input logic p, input logic l,
                       input logic first, output int waited);
    @(negedge clk);
    tif.tx_data   = d;
    tif.tx_bits   = b;
    tif.tx_par_en = p;
    tif.tx_last   = l;
    tif.tx_valid  = 1'b1;
    waited = 0;
    while (!tif.tx_ready && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 4000) chk("accept_timeout", waited, 0);
    @(posedge clk);
    if (first) go = 1'b1;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    tif.tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((run || go || sb.size() > 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("frame_timeout", t, 0);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int wt;
    clear();
    push_model(v);
    offer(v.d0, v.b0, v.p0, (v.nb == 1) ? v.lst : 1'b0, 1'b1, wt);
    if (v.nb == 2) begin
      offer(v.d1, v.b1, v.p1, v.lst, 1'b0, wt);
      chk("rdy_byte1", wt, 1);
    end
    idle_bus();
    wait_done();
    chk("wave", werr, 0);
    chk("done_at", done_idx, v.exp_len);
    chk("underrun", und_cnt, v.exp_und);
    chk("busy_idle", int'(bz1), 0);
    chk("pl20_min", wmin, PL2);
    chk("pl20_max", wmax, PL2);
  endtask

  initial begin
    vecs[0] = '{nb: 1, d0: 8'h26, d1: 8'h00, b0: 3'd7, b1: 3'd0,
                p0: 1'b0, p1: 1'b0, lst: 1'b1, exp_len: 1280, exp_und: 0};
    vecs[1] = '{nb: 2, d0: 8'h93, d1: 8'h20, b0: 3'd0, b1: 3'd0,
                p0: 1'b1, p1: 1'b1, lst: 1'b1, exp_len: 2688, exp_und: 0};
    vecs[2] = '{nb: 1, d0: 8'h93, d1: 8'h00, b0: 3'd0, b1: 3'd0,
                p0: 1'b1, p1: 1'b0, lst: 1'b0, exp_len: 1536, exp_und: 1};
    vecs[3] = '{nb: 1, d0: 8'h52, d1: 8'h00, b0: 3'd7, b1: 3'd0,
                p0: 1'b0, p1: 1'b0, lst: 1'b1, exp_len: 1280, exp_und: 0};
    vecs[4] = '{nb: 1, d0: 8'h00, d1: 8'h00, b0: 3'd0, b1: 3'd0,
                p0: 1'b1, p1: 1'b0, lst: 1'b1, exp_len: 1536, exp_und: 0};
    vecs[5] = '{nb: 1, d0: 8'hFF, d1: 8'h00, b0: 3'd0, b1: 3'd0,
                p0: 1'b0, p1: 1'b0, lst: 1'b1, exp_len: 1408, exp_und: 0};
    vecs[6] = '{nb: 1, d0: 8'h05, d1: 8'h00, b0: 3'd3, b1: 3'd0,
                p0: 1'b0, p1: 1'b0, lst: 1'b1, exp_len: 768, exp_und: 0};

    tif.tx_data = '0;
    tif.tx_bits = '0;
    tif.tx_par_en = 1'b0;
    tif.tx_last = 1'b0;
    tif.tx_valid = 1'b0;
    clear();

    repeat (3) @(negedge clk);
    chk("rst_pause", int'(mp1), 0);
    chk("rst_busy", int'(bz1), 0);
    chk("rst_done", int'(dn1), 0);
    chk("rst_underrun", int'(un1), 0);
    chk("rst_ready", int'(tif.tx_ready), 1);
    nrst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        chk("reqa_rises", rises.size(), 7);
        for (int k = 0; k < 7; k++)
          if (k < rises.size()) chk("reqa_rise_at", rises[k], exp_r[k]);
      end
    end

    clear();
    push_model(vecs[0]);
    offer(8'h26, 3'd7, 1'b0, 1'b1, 1'b1, w);
    idle_bus();
    repeat (331) @(posedge clk);
    #2;
    chk("pause_pre_rst", int'(mp1), 1);
    nrst = 1'b0;
    run = 1'b0;
    go = 1'b0;
    sb.delete();
    #1;
    chk("arst_pause", int'(mp1), 0);
    chk("arst_pause20", int'(mp2), 0);
    chk("arst_busy", int'(bz1), 0);
    chk("arst_ready", int'(tif.tx_ready), 1);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    run_vec(vecs[0]);

    clear();
    push_model(vecs[0]);
    push_model(vecs[3]);
    offer(8'h26, 3'd7, 1'b0, 1'b1, 1'b1, w);
    offer(8'h52, 3'd7, 1'b0, 1'b1, 1'b0, w);
    idle_bus();
    wait_done();
    chk("b2b_wave", werr, 0);
    chk("b2b_dones", dn_cnt, 2);
    chk("b2b_done_at", done_idx, 2561);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
